// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB arbiter types and helpers.
// AHB_ARB_DEFAULT_MASTER_EN selects the parked-grant variant of the idle state.
package ahb_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 16;
  localparam int unsigned MAX_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

`ifdef AHB_ARB_DEFAULT_MASTER_EN
  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam arb_state_e ARB_FREE = PARK;
`else
  typedef enum logic [1:0] {
    NO_OWNER = 2'd0,
    OWNED    = 2'd1,
    LOCKED   = 2'd2
  } arb_state_e;

  localparam arb_state_e ARB_FREE = NO_OWNER;
`endif

  // OR-reduction encoder; exact for one-hot or zero input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module ahb_rr_picker #(
  parameter  int unsigned MASTER_NUM = 4,
  localparam int unsigned IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [MASTER_NUM-1:0] win_oh,
  output logic                  valid
);

  logic [MASTER_NUM-1:0] rot;
  logic [MASTER_NUM-1:0] rot_oh;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot    = MASTER_NUM'({req, req} >> rr_ptr);
    rot_oh = rot & (~rot + MASTER_NUM'(1));
    win_oh = MASTER_NUM'(({rot_oh, rot_oh} << rr_ptr) >> MASTER_NUM);
    valid  = |req;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst/lock hold and lagged data-phase select.
// Define AHB_ARB_DEFAULT_MASTER_EN to park the idle grant on master 0.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter  int unsigned MASTER_NUM = 4,
  localparam int unsigned IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hbusreq,
  input  logic [MASTER_NUM-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MASTER_NUM-1:0] hsel_data,
  output logic [IDX_W-1:0]      hmaster,
  output logic                  hmaster_lock
);

`ifdef AHB_ARB_DEFAULT_MASTER_EN
  localparam logic [MASTER_NUM-1:0] FREE_GRANT = MASTER_NUM'(1);
`else
  localparam logic [MASTER_NUM-1:0] FREE_GRANT = '0;
`endif

  arb_state_e            state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MASTER_NUM-1:0] sel_data_q, sel_data_d;
  logic [IDX_W-1:0]      master_q, master_d;
  logic                  lock_q, lock_d;
  logic [IDX_W-1:0]      rr_q, rr_d;

  logic [MASTER_NUM-1:0] pick_win;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  in_burst;
  logic                  owner_req;
  logic                  owner_lock;
  logic                  arb;

  ahb_rr_picker #(
    .MASTER_NUM (MASTER_NUM)
  ) u_picker (
    .req    (hbusreq),
    .rr_ptr (rr_q),
    .win_oh (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_data_d = sel_data_q;
    lock_d     = lock_q;
    rr_d       = rr_q;
    arb        = 1'b0;

    pick_idx   = IDX_W'(onehot_to_idx(MAX_MASTERS'(pick_win)));
    in_burst   = (htrans_t'(htrans) == SEQ) || (htrans_t'(htrans) == BUSY);
    owner_req  = |(grant_q & hbusreq);
    owner_lock = |(grant_q & hbusreq & hlock);

    if (hready) begin
      sel_data_d = grant_q;

      unique case (state_q)
        OWNED: begin
          if (!in_burst) arb = 1'b1;
        end
        LOCKED: begin
          if (owner_lock) begin
            arb = 1'b0;
          end else if (owner_req && in_burst) begin
            state_d = OWNED;
            lock_d  = 1'b0;
          end else begin
            arb = 1'b1;
          end
        end
        default: arb = 1'b1;
      endcase

      if (arb) begin
        if (pick_valid) begin
          grant_d = pick_win;
          lock_d  = |(pick_win & hlock);
          state_d = lock_d ? LOCKED : OWNED;
          // Pointer moves only when ownership actually changes hands.
          if (state_q == ARB_FREE || pick_win != grant_q) begin
            rr_d = (32'(pick_idx) == MASTER_NUM - 1) ? '0 : IDX_W'(pick_idx + IDX_W'(1));
          end
        end else begin
          grant_d = FREE_GRANT;
          lock_d  = 1'b0;
          state_d = ARB_FREE;
        end
      end
    end

    master_d = IDX_W'(onehot_to_idx(MAX_MASTERS'(grant_d)));
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= ARB_FREE;
      grant_q    <= FREE_GRANT;
      sel_data_q <= '0;
      master_q   <= '0;
      lock_q     <= 1'b0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_data_q <= sel_data_d;
      master_q   <= master_d;
      lock_q     <= lock_d;
      rr_q       <= rr_d;
    end
  end

  assign hgrant       = grant_q;
  assign hsel_data    = sel_data_q;
  assign hmaster      = master_q;
  assign hmaster_lock = lock_q;

endmodule
